// File: rtl/imem_sync.sv
// imem_sync: handshaked instruction memory with wait states and program-load write port.
// Optional IMEM_MISALIGN_TRAP_EN: misaligned fetches respond with err=1 and a NOP.
module imem_sync #(
  parameter int    Word_size   = 32,
  parameter int    Addr_bits   = 32,
  parameter int    Depth       = 256,
  parameter int    Wait_cycles = 2,
  parameter string Init_file   = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [Addr_bits-1:0] addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [Word_size-1:0] instr,
  output logic                 err,
  input  logic                 we,
  input  logic [Addr_bits-1:0] w_addr,
  input  logic [Word_size-1:0] w_data
);
  localparam int IW = $clog2(Depth);
  localparam logic [Word_size-1:0] NOP = Word_size'(32'h0000_0013);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d, a_idx, rd_idx;
  logic [Word_size-1:0] instr_q, instr_d;
  logic [Word_size-1:0] mem [Depth];
  logic err_q, err_d, load, mis;
  logic unused_ok;
  assign unused_ok = ^{addr, w_addr};
  assign a_idx = addr[2 +: IW];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = Wait_cycles == 0 ? RESP : WAIT;
        cnt_d = 4'(Wait_cycles);
        idx_d = a_idx;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Zero wait states read straight from the request address on the accepting edge.
  assign load = state_d == RESP && state_q != RESP;
  assign rd_idx = state_q == IDLE ? a_idx : idx_q;
`ifdef IMEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis = state_q == IDLE ? addr[1:0] != 2'b00 : mis_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mis_q <= 1'b0;
    else mis_q <= mis;
`else
  assign mis = 1'b0;
`endif
  assign instr_d = !load ? instr_q : mis ? NOP : mem[rd_idx];
  assign err_d = load ? mis : err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      instr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      instr_q <= instr_d;
      err_q <= err_d;
    end
  // Non-blocking update gives read-before-write on a same-edge collision.
  always_ff @(posedge clk)
    if (we) mem[w_addr[2 +: IW]] <= w_data;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign instr = instr_q;
  assign err = err_q;
endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: randomized self-checking bench for imem_sync against an array model.
module tb_imem_sync;
  localparam int WS = 32;
  localparam int DEPTH = 16;
  localparam int W = 2;
  localparam int IW = $clog2(DEPTH);
  localparam logic [WS-1:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0, we = 0;
  logic req_ready, rsp_valid, err;
  logic [31:0] addr = 0, w_addr = 0;
  logic [WS-1:0] w_data = 0, instr;
  logic [WS-1:0] model [DEPTH];
  int errors = 0, checks = 0;

  imem_sync #(.Word_size(WS), .Addr_bits(32), .Depth(DEPTH), .Wait_cycles(W), .Init_file("")) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .addr(addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .instr(instr), .err(err),
    .we(we), .w_addr(w_addr), .w_data(w_data));

  always #5 clk = ~clk;

  function automatic logic [31:0] waddr_of(input logic [IW-1:0] wi);
    logic [31:0] wa;
    wa = $urandom;
    wa[2 +: IW] = wi;
    return wa;
  endfunction

  task automatic write_word(input logic [IW-1:0] wi, input logic [WS-1:0] wd);
    we = 1; w_addr = waddr_of(wi); w_data = wd;
    @(posedge clk); @(negedge clk);
    we = 0;
    model[wi] = wd;
  endtask

  // Fetch with optional write on edge number wr_edge (1 = accepting edge); the array is read on edge W+1.
  task automatic fetch(input logic [31:0] a, input int hold, input int wr_edge,
                       input logic [IW-1:0] wi, input logic [WS-1:0] wd, input string nm);
    logic [WS-1:0] exp;
    logic exp_err;
    logic [IW-1:0] ix;
    int e;
    ix = a[2 +: IW];
    exp = model[ix];
    exp_err = 0;
    if (wr_edge != 0 && wr_edge <= W && wi == ix) exp = wd;
`ifdef IMEM_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) begin exp = NOP; exp_err = 1; end
`endif
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready: got %b want 1", nm, req_ready); end
    req_valid = 1; addr = a; rsp_ready = 0; e = 0;
    do begin
      we = (e + 1 == wr_edge); w_addr = waddr_of(wi); w_data = wd;
      @(posedge clk); e++; @(negedge clk);
      req_valid = 0; we = 0;
      if (!rsp_valid) begin
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL %s busy_ready: got %b want 0 at edge %0d", nm, req_ready, e); end
      end
    end while (!rsp_valid && e < 40);
    checks++;
    if (e != W + 1) begin errors++; $display("FAIL %s latency: got %0d edges want %0d", nm, e, W + 1); end
    checks++;
    if (instr !== exp || err !== exp_err)
      begin errors++; $display("FAIL %s data: got instr=%h err=%b want instr=%h err=%b", nm, instr, err, exp, exp_err); end
    for (int h = 0; h < hold; h++) begin
      we = (e + 1 == wr_edge); w_addr = waddr_of(wi); w_data = wd;
      @(posedge clk); e++; @(negedge clk);
      we = 0;
      checks++;
      if (rsp_valid !== 1'b1 || instr !== exp || err !== exp_err || req_ready !== 1'b0)
        begin errors++; $display("FAIL %s hold%0d: got v=%b instr=%h err=%b rdy=%b want v=1 instr=%h err=%b rdy=0", nm, h, rsp_valid, instr, err, req_ready, exp, exp_err); end
    end
    rsp_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", nm, rsp_valid, req_ready); end
    if (wr_edge != 0 && wr_edge <= e) model[wi] = wd;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || instr !== '0 || err !== 1'b0)
      begin errors++; $display("FAIL reset: got rdy=%b v=%b instr=%h err=%b want 1 0 0 0", req_ready, rsp_valid, instr, err); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    write_word(0, 'h11); write_word(1, 'h22); write_word(2, 'h33); write_word(3, 'h44);
    fetch(32'h8, 5, 0, 0, 0, "basic_backpressure");
    fetch(32'h4 + 4 * DEPTH, 0, 0, 0, 0, "wrap");
    fetch(32'h4, 0, W + 1, 1, 'hAA, "same_edge_write");
    fetch(32'h4, 0, 0, 0, 0, "after_write");
    fetch(32'hC, 3, W + 2, 3, 'h55, "write_during_resp");
    fetch(32'h6, 1, 0, 0, 0, "misaligned");
  endtask

  task automatic test_reset_mid_wait;
    req_valid = 1; addr = 32'h8;
    @(posedge clk); @(negedge clk);
    req_valid = 0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_wait_busy: got rdy=%b want 0", req_ready); end
    rst_n = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || instr !== '0)
      begin errors++; $display("FAIL async_reset: got v=%b rdy=%b instr=%h want 0 1 0", rsp_valid, req_ready, instr); end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
        begin errors++; $display("FAIL stale_rsp%0d: got v=%b rdy=%b want 0 1", i, rsp_valid, req_ready); end
    end
    fetch(32'h8, 0, 0, 0, 0, "mem_survives_reset");
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      logic [IW-1:0] wi;
      int hold;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      wi = $urandom_range(0, 1) != 0 ? a[2 +: IW] : IW'($urandom);
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) write_word(IW'($urandom), $urandom);
      fetch(a, hold, $urandom_range(0, W + 1 + hold), wi, $urandom, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;
    test_reset;
    for (int i = 0; i < DEPTH; i++) write_word(IW'(i), $urandom);
    test_directed;
    test_reset_mid_wait;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
